// File: rtl/mem_stage_pipe.sv
// MEM stage: holds one instruction and waits on data-SRAM data_ok. A load leaves in the cycle its response arrives.
// Backpressure: ws_allowin low parks the instruction and buffers its response. Responses owned by flushed loads are counted and discarded.
module mem_stage_pipe #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int RF_AW  = 5,
    parameter int DROP_W = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              es2ms_valid,
    output logic              ms_allowin,
    input  logic [PC_W-1:0]   es_pc,
    input  logic [DATA_W-1:0] es_alu_result,
    input  logic              es_rf_we,
    input  logic [RF_AW-1:0]  es_rf_waddr,
    input  logic              es_res_from_mem,
    input  logic              es_mem_req,
    input  logic [2:0]        es_ld_op,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    output logic              ms2ws_valid,
    input  logic              ws_allowin,
    output logic [PC_W-1:0]   ms_pc,
    output logic              ms_rf_we,
    output logic [RF_AW-1:0]  ms_rf_waddr,
    output logic [DATA_W-1:0] ms_rf_wdata,
    output logic              ms_fwd_valid,
    output logic              ms_ld_busy
);

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    logic              ms_valid;
    logic [PC_W-1:0]   pc_r;
    logic [DATA_W-1:0] alu_r;
    logic              rf_we_r;
    logic [RF_AW-1:0]  waddr_r;
    logic              res_from_mem_r;
    logic              mem_req_r;
    logic [2:0]        ld_op_r;
    logic              buf_valid;
    logic [DATA_W-1:0] buf_dat;
    logic [DROP_W-1:0] drop_cnt;

    logic drop_pending, resp_take, ms_ready_go, ms_leave, es_accept;
    logic buf_fill, drop_inc, drop_dec;

    // A response is ours only when no flushed request is still ahead of it.
    assign drop_pending = (drop_cnt != '0);
    assign resp_take    = data_sram_data_ok & ~drop_pending;
    assign ms_ready_go  = ~mem_req_r | buf_valid | resp_take;
    assign ms_allowin   = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms2ws_valid  = ms_valid & ms_ready_go & ~flush;
    assign ms_leave     = ms2ws_valid & ws_allowin;
    assign es_accept    = es2ms_valid & ms_allowin & ~flush;
    assign buf_fill     = resp_take & ms_valid & mem_req_r & ~buf_valid & ~ws_allowin & ~flush;
    assign drop_inc     = flush & ms_valid & mem_req_r & ~buf_valid & ~resp_take;
    assign drop_dec     = data_sram_data_ok & drop_pending;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid       <= 1'b0;
            pc_r           <= '0;
            alu_r          <= '0;
            rf_we_r        <= 1'b0;
            waddr_r        <= '0;
            res_from_mem_r <= 1'b0;
            mem_req_r      <= 1'b0;
            ld_op_r        <= '0;
            buf_valid      <= 1'b0;
            buf_dat        <= '0;
            drop_cnt       <= '0;
        end else begin
            if (flush)
                ms_valid <= 1'b0;
            else if (ms_allowin)
                ms_valid <= es2ms_valid;

            if (es_accept) begin
                pc_r           <= es_pc;
                alu_r          <= es_alu_result;
                rf_we_r        <= es_rf_we;
                waddr_r        <= es_rf_waddr;
                res_from_mem_r <= es_res_from_mem;
                mem_req_r      <= es_mem_req;
                ld_op_r        <= es_ld_op;
            end

            if (flush || es_accept || ms_leave)
                buf_valid <= 1'b0;
            else if (buf_fill)
                buf_valid <= 1'b1;

            if (buf_fill)
                buf_dat <= data_sram_rdata;

            case ({drop_inc, drop_dec})
                2'b10:   drop_cnt <= drop_cnt + 1'b1;
                2'b01:   drop_cnt <= drop_cnt - 1'b1;
                default: drop_cnt <= drop_cnt;
            endcase
        end
    end

    logic [DATA_W-1:0] raw;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] ld_data;

    always_comb begin
        raw      = buf_valid ? buf_dat : data_sram_rdata;
        byte_sel = raw[{alu_r[1:0], 3'b000} +: 8];
        half_sel = raw[{alu_r[1], 4'b0000} +: 16];
        case (ld_op_r)
            LD_LB:   ld_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_LBU:  ld_data = {{(DATA_W-8){1'b0}}, byte_sel};
            LD_LH:   ld_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LD_LHU:  ld_data = {{(DATA_W-16){1'b0}}, half_sel};
            default: ld_data = raw;
        endcase
    end

    assign ms_pc        = pc_r;
    assign ms_rf_we     = ms_valid & rf_we_r;
    assign ms_rf_waddr  = waddr_r;
    assign ms_rf_wdata  = res_from_mem_r ? ld_data : alu_r;
    assign ms_fwd_valid = ms_rf_we & ms_ready_go;
    assign ms_ld_busy   = ms_valid & res_from_mem_r & ~ms_ready_go;

endmodule
